pio_loader: RTL and testbench

Sequencer that configures one PIO state machine from a program ROM plus latched config words. It replaces hand-written bench/firmware action sequences. On `start` it streams every instruction into the PIO, then issues the fixed configuration sequence (wrap end, divider, pin groups, side-set, shift thresholds, auto-pull/push, enable). It sits between the SoC control registers and the `pio` action/index/mindex/din port, and owns that port while busy.

---
 rtl/pio_loader.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_pio_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_loader.sv
// pio_loader
//
// Loads one PIO state machine from a program ROM and a set of configuration
// words. On start it latches the configuration and streams every instruction
// word into the PIO action port. It then issues a fixed sequence of
// configuration writes: program end, divider, pin groups, side-set, OSR/ISR
// thresholds, auto-pull, auto-push and enable. The block owns the
// action/index/mindex/din port while busy.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous, active-low reset
//   start        begin a load (accepted in IDLE only)
//   abort        cancel a load in progress (wins over start in IDLE)
//   cfg_*        configuration words, latched on an accepted start
//   prog_addr    program ROM address (synchronous ROM, 1-cycle latency)
//   prog_data    ROM data for the address presented in the previous cycle
//   action       PIO action code
//   index        instruction index for INSTR writes
//   mindex       target state machine (latched cfg_mindex)
//   din          PIO write data
//   busy         high in every state except IDLE
//   done         one-cycle pulse in the final cycle of a completed load
module pio_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        cfg_mindex,
    input  logic [5:0]        cfg_plen,
    input  logic [23:0]       cfg_div,
    input  logic [31:0]       cfg_grps,
    input  logic [5:0]        cfg_sides,
    input  logic [5:0]        cfg_osrt,
    input  logic [5:0]        cfg_isrt,
    input  logic              cfg_apull,
    input  logic              cfg_apush,
    input  logic [3:0]        cfg_en,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    output logic [3:0]        action,
    output logic [4:0]        index,
    output logic [1:0]        mindex,
    output logic [31:0]       din,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_SIDES = 4'd8;
    localparam logic [3:0] ACT_APUSH = 4'd10;
    localparam logic [3:0] ACT_APULL = 4'd11;
    localparam logic [3:0] ACT_ISRT  = 4'd14;
    localparam logic [3:0] ACT_OSRT  = 4'd15;

    localparam logic [5:0] CFG_LAST = 6'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_CFG,
        S_DONE
    } state_t;

    // Sequencer state. cnt holds the instruction index in LOAD and the
    // configuration step in CFG.
    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;

    // Configuration shadows, captured on an accepted start.
    logic [1:0]  mindex_q, mindex_d;
    logic [5:0]  plen_q, plen_d;
    logic [23:0] div_q, div_d;
    logic [31:0] grps_q, grps_d;
    logic [5:0]  sides_q, sides_d;
    logic [5:0]  osrt_q, osrt_d;
    logic [5:0]  isrt_q, isrt_d;
    logic        apull_q, apull_d;
    logic        apush_q, apush_d;
    logic [3:0]  en_q, en_d;

    // Registered outputs, decoded from the next state so they line up with it.
    logic [3:0]        action_q, action_d;
    logic [4:0]        index_q, index_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [31:0]       din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state and shadow capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mindex_d = mindex_q;
        plen_d   = plen_q;
        div_d    = div_q;
        grps_d   = grps_q;
        sides_d  = sides_q;
        osrt_d   = osrt_q;
        isrt_d   = isrt_q;
        apull_d  = apull_q;
        apush_d  = apush_q;
        en_d     = en_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_FETCH;
                    cnt_d    = 6'd0;
                    mindex_d = cfg_mindex;
                    plen_d   = cfg_plen;
                    div_d    = cfg_div;
                    grps_d   = cfg_grps;
                    sides_d  = cfg_sides;
                    osrt_d   = cfg_osrt;
                    isrt_d   = cfg_isrt;
                    apull_d  = cfg_apull;
                    apush_d  = cfg_apush;
                    en_d     = cfg_en;
                end
            end
            S_FETCH: begin
                cnt_d   = 6'd0;
                state_d = (plen_q != 6'd0) ? S_LOAD : S_CFG;
            end
            S_LOAD: begin
                if (cnt_q == plen_q - 6'd1) begin
                    state_d = S_CFG;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_CFG: begin
                if (cnt_q == CFG_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        // Abort overrides any transition while busy; shadows keep their values
        // so mindex holds in IDLE.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
        end
    end

    // Output decode for the cycle that follows the coming edge.
    always_comb begin
        action_d    = ACT_NONE;
        index_d     = 5'd0;
        prog_addr_d = '0;
        din_d       = 32'd0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);

        case (state_d)
            S_LOAD: begin
                action_d    = ACT_INSTR;
                index_d     = cnt_d[4:0];
                // Prefetch the next word; the wrap at a full-length program
                // fetches a word that is never used.
                prog_addr_d = ADDR_W'(cnt_d + 6'd1);
            end
            S_CFG: begin
                case (cnt_d)
                    6'd0: begin
                        action_d = ACT_PEND;
                        din_d    = (plen_d == 6'd0) ? 32'd0 : {26'd0, plen_d - 6'd1};
                    end
                    6'd1: begin
                        action_d = ACT_DIV;
                        din_d    = {8'd0, div_d};
                    end
                    6'd2: begin
                        action_d = ACT_GRPS;
                        din_d    = grps_d;
                    end
                    6'd3: begin
                        action_d = ACT_SIDES;
                        din_d    = {26'd0, sides_d};
                    end
                    6'd4: begin
                        action_d = ACT_OSRT;
                        din_d    = {26'd0, osrt_d};
                    end
                    6'd5: begin
                        action_d = ACT_ISRT;
                        din_d    = {26'd0, isrt_d};
                    end
                    6'd6: begin
                        action_d = ACT_APULL;
                        din_d    = {31'd0, apull_d};
                    end
                    6'd7: begin
                        action_d = ACT_APUSH;
                        din_d    = {31'd0, apush_d};
                    end
                    6'd8: begin
                        action_d = ACT_EN;
                        din_d    = {28'd0, en_d};
                    end
                    default: begin
                        action_d = ACT_NONE;
                        din_d    = 32'd0;
                    end
                endcase
            end
            default: begin
                action_d = ACT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            mindex_q    <= 2'd0;
            plen_q      <= 6'd0;
            div_q       <= 24'd0;
            grps_q      <= 32'd0;
            sides_q     <= 6'd0;
            osrt_q      <= 6'd0;
            isrt_q      <= 6'd0;
            apull_q     <= 1'b0;
            apush_q     <= 1'b0;
            en_q        <= 4'd0;
            action_q    <= ACT_NONE;
            index_q     <= 5'd0;
            prog_addr_q <= '0;
            din_q       <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mindex_q    <= mindex_d;
            plen_q      <= plen_d;
            div_q       <= div_d;
            grps_q      <= grps_d;
            sides_q     <= sides_d;
            osrt_q      <= osrt_d;
            isrt_q      <= isrt_d;
            apull_q     <= apull_d;
            apush_q     <= apush_d;
            en_q        <= en_d;
            action_q    <= action_d;
            index_q     <= index_d;
            prog_addr_q <= prog_addr_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ROM data only becomes valid during the LOAD cycle itself, so instruction
    // words pass straight through. Every other din value comes from the register.
    assign din       = (state_q == S_LOAD) ? {16'd0, prog_data} : din_q;
    assign action    = action_q;
    assign index     = index_q;
    assign prog_addr = prog_addr_q;
    assign mindex    = mindex_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pio_loader.sv
module tb_pio_loader;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [1:0]        cfg_mindex;
    logic [5:0]        cfg_plen;
    logic [23:0]       cfg_div;
    logic [31:0]       cfg_grps;
    logic [5:0]        cfg_sides;
    logic [5:0]        cfg_osrt;
    logic [5:0]        cfg_isrt;
    logic              cfg_apull;
    logic              cfg_apush;
    logic [3:0]        cfg_en;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic [3:0]        action;
    logic [4:0]        index;
    logic [1:0]        mindex;
    logic [31:0]       din;
    logic              busy;
    logic              done;

    logic [15:0] rom [32];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Synchronous program ROM with one cycle of read latency.
    always @(posedge clk) prog_data <= rom[prog_addr];

    pio_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_mindex (cfg_mindex),
        .cfg_plen   (cfg_plen),
        .cfg_div    (cfg_div),
        .cfg_grps   (cfg_grps),
        .cfg_sides  (cfg_sides),
        .cfg_osrt   (cfg_osrt),
        .cfg_isrt   (cfg_isrt),
        .cfg_apull  (cfg_apull),
        .cfg_apush  (cfg_apush),
        .cfg_en     (cfg_en),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .action     (action),
        .index      (index),
        .mindex     (mindex),
        .din        (din),
        .busy       (busy),
        .done       (done)
    );

    // Expected port contents for one busy cycle; ci/cd/cp select which of
    // index, din and prog_addr carry a defined value in that cycle.
    typedef struct packed {
        logic [3:0]  act;
        logic [4:0]  idx;
        logic [31:0] din;
        logic [4:0]  pa;
        logic        done;
        logic        ci;
        logic        cd;
        logic        cp;
    } cyc_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [1:0] exp_mindex);
        check_eq({tag, " busy"},   32'(busy),   32'd0);
        check_eq({tag, " done"},   32'(done),   32'd0);
        check_eq({tag, " action"}, 32'(action), 32'd0);
        check_eq({tag, " mindex"}, 32'(mindex), 32'(exp_mindex));
    endtask

    task automatic rand_cfg(input int plen);
        cfg_plen   = 6'(plen);
        cfg_mindex = 2'($urandom);
        cfg_div    = 24'($urandom);
        cfg_grps   = $urandom;
        cfg_sides  = 6'($urandom);
        cfg_osrt   = 6'($urandom);
        cfg_isrt   = 6'($urandom);
        cfg_apull  = 1'($urandom);
        cfg_apush  = 1'($urandom);
        cfg_en     = 4'($urandom);
        for (int j = 0; j < 32; j++) rom[j] = 16'($urandom);
    endtask

    // mode 0: plain load; 1: abort at expected cycle k; 2: change cfg_div in
    // LOAD and re-pulse start at cycle k; 3: assert reset at cycle k.
    task automatic run_load(input string name, input int mode, input int k);
        cyc_t        q[$];
        cyc_t        e;
        logic [31:0] vals [9];
        logic [3:0]  acts [9];
        int          plen;
        logic [1:0]  mi;

        plen = int'(cfg_plen);
        mi   = cfg_mindex;
        acts = '{4'd2, 4'd7, 4'd5, 4'd8, 4'd15, 4'd14, 4'd11, 4'd10, 4'd6};
        vals[0] = (plen == 0) ? 32'd0 : 32'(plen - 1);
        vals[1] = 32'(cfg_div);
        vals[2] = cfg_grps;
        vals[3] = 32'(cfg_sides);
        vals[4] = 32'(cfg_osrt);
        vals[5] = 32'(cfg_isrt);
        vals[6] = 32'(cfg_apull);
        vals[7] = 32'(cfg_apush);
        vals[8] = 32'(cfg_en);

        e = '0; e.cp = 1'b1;
        q.push_back(e);
        for (int i = 0; i < plen; i++) begin
            e = '0;
            e.act = 4'd1; e.idx = 5'(i); e.din = {16'd0, rom[i]};
            e.pa = 5'((i + 1) % 32); e.ci = 1'b1; e.cd = 1'b1; e.cp = 1'b1;
            q.push_back(e);
        end
        for (int s = 0; s < 9; s++) begin
            e = '0; e.act = acts[s]; e.din = vals[s]; e.cd = 1'b1;
            q.push_back(e);
        end
        e = '0; e.done = 1'b1;
        q.push_back(e);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        for (int c = 0; c < q.size(); c++) begin
            string t;
            @(negedge clk);
            e = q[c];
            t = $sformatf("%s c%0d", name, c);
            check_eq({t, " action"}, 32'(action), 32'(e.act));
            check_eq({t, " busy"},   32'(busy),   32'd1);
            check_eq({t, " done"},   32'(done),   32'(e.done));
            check_eq({t, " mindex"}, 32'(mindex), 32'(mi));
            if (e.ci) check_eq({t, " index"},     32'(index),     32'(e.idx));
            if (e.cd) check_eq({t, " din"},       din,            e.din);
            if (e.cp) check_eq({t, " prog_addr"}, 32'(prog_addr), 32'(e.pa));

            if (mode == 1 && c == k) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_idle({name, " after abort"}, mi);
                for (int w = 0; w < 3; w++) begin
                    @(negedge clk);
                    check_idle($sformatf("%s idle%0d", name, w), mi);
                end
                return;
            end
            if (mode == 2 && c == 2) cfg_div = ~cfg_div;
            if (mode == 2 && c == k) begin
                start = 1'b1;
                cfg_div = 24'($urandom);
                cfg_mindex = ~cfg_mindex;
            end
            if (mode == 2 && c == k + 1) start = 1'b0;
            if (mode == 3 && c == k) begin
                #2 reset = 1'b0;
                #1;
                check_eq({name, " rst action"},    32'(action),    32'd0);
                check_eq({name, " rst index"},     32'(index),     32'd0);
                check_eq({name, " rst mindex"},    32'(mindex),    32'd0);
                check_eq({name, " rst din"},       din,            32'd0);
                check_eq({name, " rst prog_addr"}, 32'(prog_addr), 32'd0);
                check_eq({name, " rst busy"},      32'(busy),      32'd0);
                check_eq({name, " rst done"},      32'(done),      32'd0);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check_idle({name, " post-rst"}, 2'd0);
                return;
            end
        end
        @(negedge clk);
        check_idle({name, " end"}, mi);
        check_eq({name, " end prog_addr"}, 32'(prog_addr), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rand_cfg(0);
        #1 reset = 1'b0;
        #1;
        check_eq("reset action", 32'(action), 32'd0);
        check_eq("reset index",  32'(index),  32'd0);
        check_eq("reset din",    din,         32'd0);
        check_eq("reset busy",   32'(busy),   32'd0);
        check_eq("reset done",   32'(done),   32'd0);
        check_eq("reset mindex", 32'(mindex), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reference program from the bring-up sequence.
        rand_cfg(2);
        rom[0] = 16'h6001; rom[1] = 16'h0000;
        cfg_mindex = 2'd0; cfg_div = 24'h000C80; cfg_grps = 32'h20100001;
        cfg_sides = 6'h21; cfg_osrt = 6'h28; cfg_isrt = 6'd8;
        cfg_apull = 1'b1; cfg_apush = 1'b1; cfg_en = 4'd1;
        run_load("basic", 0, 0);

        rand_cfg(0);
        run_load("plen0", 0, 0);

        rand_cfg(32);
        for (int j = 0; j < 32; j++) rom[j] = 16'(j);
        run_load("plen32", 0, 0);

        // Abort at LOAD i=3 of an 8-word program (cycle 1+3), then reload.
        rand_cfg(8);
        run_load("abort", 1, 4);
        rand_cfg(8);
        run_load("after_abort", 0, 0);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("start+abort busy", 32'(busy), 32'd0);

        // Disturb cfg_div during LOAD and re-pulse start at CFG s=3.
        rand_cfg(5);
        run_load("disturb", 2, 1 + 5 + 3);

        // Reset at CFG s=4, then a full load.
        rand_cfg(6);
        run_load("reset_cfg", 3, 1 + 6 + 4);
        rand_cfg(3);
        run_load("after_reset", 0, 0);

        for (int r = 0; r < 20; r++) begin
            rand_cfg($urandom_range(0, 32));
            run_load($sformatf("rand%0d", r), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
